// File: rtl/pipelined_carry_adder_if.sv
// Valid/ready operand and result bundle for pipelined_carry_adder.
// Optional ovf signal exists only when ADDER_OVERFLOW_EN is defined.
interface pipelined_carry_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
`ifdef ADDER_OVERFLOW_EN
        input  ovf,
`endif
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
`ifdef ADDER_OVERFLOW_EN
        output ovf,
`endif
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/subtract split into STAGES chunk ripple adders with a register slice per chunk.
// Optional signed-overflow output enabled by defining ADDER_OVERFLOW_EN.
module pipelined_carry_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    pipelined_carry_adder_if.slave bus
);
    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned CW    = CHUNK + 1;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_b_eff = bus.sub ? ~bus.b : bus.b;
    assign w_c0    = bus.sub | bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0]         w_a;
        logic [CHUNK-1:0]         w_b;
        logic                     w_c;
        logic                     w_v;
        logic [CW-1:0]            w_add;
        logic [(k+1)*CHUNK-1:0]   w_s_next;
        logic                     r_v;
        logic                     r_c;
        logic [(k+1)*CHUNK-1:0]   r_s;

        // Chunk operands come from the inputs for stage 0, else from the previous slice.
        if (k == 0) begin : g_src
            assign w_a      = bus.a[CHUNK-1:0];
            assign w_b      = w_b_eff[CHUNK-1:0];
            assign w_c      = w_c0;
            assign w_v      = bus.in_valid;
            assign w_s_next = w_add[CHUNK-1:0];
        end else begin : g_src
            assign w_a      = g_stage[k-1].g_fwd.r_a[CHUNK-1:0];
            assign w_b      = g_stage[k-1].g_fwd.r_b[CHUNK-1:0];
            assign w_c      = g_stage[k-1].r_c;
            assign w_v      = g_stage[k-1].r_v;
            assign w_s_next = {w_add[CHUNK-1:0], g_stage[k-1].r_s};
        end

        assign w_add = CW'(w_a) + CW'(w_b) + CW'(w_c);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v;
                r_c <= w_add[CHUNK];
                r_s <= w_s_next;
            end
        end

        // Operand bits not yet summed travel alongside, shrinking by one chunk per stage.
        if (k < STAGES - 1) begin : g_fwd
            localparam int unsigned HI = WIDTH - (k + 1) * CHUNK;
            logic [HI-1:0] w_a_up;
            logic [HI-1:0] w_b_up;
            logic [HI-1:0] r_a;
            logic [HI-1:0] r_b;

            if (k == 0) begin : g_up
                assign w_a_up = bus.a[WIDTH-1:CHUNK];
                assign w_b_up = w_b_eff[WIDTH-1:CHUNK];
            end else begin : g_up
                assign w_a_up = g_stage[k-1].g_fwd.r_a[HI+CHUNK-1:CHUNK];
                assign w_b_up = g_stage[k-1].g_fwd.r_b[HI+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_up;
                    r_b <= w_b_up;
                end
            end
        end

`ifdef ADDER_OVERFLOW_EN
        // Last chunk holds the MSBs, so signed overflow is resolved here.
        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= (w_a[CHUNK-1] == w_b[CHUNK-1]) && (w_add[CHUNK-1] != w_a[CHUNK-1]);
                end
            end
        end
`endif
    end

    // Whole pipe moves together whenever the output slot is free or being drained.
    assign w_adv         = !g_stage[STAGES-1].r_v || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stage[STAGES-1].r_v;
    assign bus.sum       = g_stage[STAGES-1].r_s;
    assign bus.cout      = g_stage[STAGES-1].r_c;
`ifdef ADDER_OVERFLOW_EN
    assign bus.ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder: directed vector table plus stream, stall and reset sequences.
// Define ADDER_OVERFLOW_EN to also check ovf.
module tb_pipelined_carry_adder;
    parameter int unsigned STAGES = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned WP    = WIDTH + 1;
    localparam int unsigned NV    = 12;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_out  = 0;
    exp_t q[$];
    vec_t vecs[NV];

    pipelined_carry_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_carry_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   t;
        exp_t             e;
        be     = sub ? ~b : b;
        t      = WP'(a) + WP'(be) + WP'(sub ? 1'b1 : cin);
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard: compare the output slot against the oldest accepted op every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = q[0];
                    check("stream_sum", 32'(bus.sum), 32'(e.sum));
                    check("stream_cout", 32'(bus.cout), 32'(e.cout));
`ifdef ADDER_OVERFLOW_EN
                    check("stream_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        end
    end

    task automatic run_one(input vec_t v);
        int lat;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.cin      = v.cin;
        bus.sub      = v.sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < int'(4 * STAGES + 8)) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", 32'(lat), STAGES);
        check("vec_sum", 32'(bus.sum), 32'(v.exp_sum));
        check("vec_cout", 32'(bus.cout), 32'(v.exp_cout));
`ifdef ADDER_OVERFLOW_EN
        check("vec_ovf", 32'(bus.ovf), 32'(v.exp_ovf));
`endif
        @(posedge clk);
        #1 check("single_pulse", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic send_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub);
        logic f;
        int   guard;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        guard        = 0;
        do begin
            @(negedge clk);
            f = bus.in_ready;
            @(posedge clk);
            #1 guard++;
        end while (!f && guard < 100);
        if (!f) check("send_timeout", 32'(f), 32'd1);
    endtask

    task automatic drain(input int expect_n, input int base);
        repeat (2 * STAGES + 10) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
        check("out_count", 32'(n_out - base), 32'(expect_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        vecs[0]  = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
`ifdef ADDER_OVERFLOW_EN
        check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, one at a time.
        for (int i = 0; i < int'(NV); i++) run_one(vecs[i]);

        // Back-to-back stream.
        base = n_out;
        for (int i = 0; i < 8; i++)
            send_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        bus.in_valid = 1'b0;
        drain(8, base);

        // Stream with a six-cycle downstream stall.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                bus.in_valid = 1'b0;
            end
            begin
                repeat (STAGES + 1) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain(12, base);

        // Reset with operations in flight.
        send_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        send_op(16'h4321, 16'h0101, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * STAGES + 4) @(posedge clk);
        #1 check("post_rst_idle", 32'(bus.out_valid), 32'd0);

        // Pipe must still work after the reset.
        run_one(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
